// File: rtl/hwpe_stream_package.sv
// Shared HWPE-Stream types. ctrl_serdes_t is the common control word of the
// stream serializer and deserializer.
package hwpe_stream_package;

    typedef struct packed {
        logic       clear_serdes_state;
        logic [9:0] first_stream;
    } ctrl_serdes_t;

endpackage

// File: rtl/hwpe_stream_serialize_pkg.sv
// Local types of the stream serializer: state encoding of the output skid buffer.
package hwpe_stream_serialize_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// HWPE-Stream handshake interface.
//   valid/data/strb : producer -> consumer
//   ready           : consumer -> producer
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport sink   (input  valid, data, strb, output ready);
    modport source (output valid, data, strb, input  ready);

endinterface

// File: rtl/hwpe_stream_skid_buffer.sv
// Two-entry registered skid buffer. Output valid/data/strb and input ready
// all come straight from flops, so no combinational path crosses it.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : synchronous flush (wins over any handshake)
//   push_i        : sink side
//   pop_o         : source side, head entry
//
// state     | meaning
// ----------|---------------------------------------------
// BUF_EMPTY | nothing stored, pop_o.valid low
// BUF_ONE   | head valid, one free slot
// BUF_FULL  | head and tail valid, push_i.ready low
module hwpe_stream_skid_buffer
    import hwpe_stream_serialize_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    hwpe_stream_intf_stream.sink   push_i,
    hwpe_stream_intf_stream.source pop_o
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    buf_state_e              state_q, state_d;
    logic [DATA_WIDTH-1:0]   head_data_q, head_data_d;
    logic [DATA_WIDTH-1:0]   tail_data_q, tail_data_d;
    logic [STRB_W-1:0]       head_strb_q, head_strb_d;
    logic [STRB_W-1:0]       tail_strb_q, tail_strb_d;
    logic                    in_hs;
    logic                    out_hs;

    assign push_i.ready = (state_q != BUF_FULL);
    assign pop_o.valid  = (state_q != BUF_EMPTY);
    assign pop_o.data   = head_data_q;
    assign pop_o.strb   = head_strb_q;

    assign in_hs  = push_i.valid & push_i.ready;
    assign out_hs = pop_o.valid & pop_o.ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        tail_data_d = tail_data_q;
        head_strb_d = head_strb_q;
        tail_strb_d = tail_strb_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (in_hs) begin
                    state_d     = BUF_ONE;
                    head_data_d = push_i.data;
                    head_strb_d = push_i.strb;
                end
            end
            BUF_ONE: begin
                if (in_hs && !out_hs) begin
                    state_d     = BUF_FULL;
                    tail_data_d = push_i.data;
                    tail_strb_d = push_i.strb;
                end else if (in_hs && out_hs) begin
                    head_data_d = push_i.data;
                    head_strb_d = push_i.strb;
                end else if (out_hs) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                // ready is low here, so only a pop can happen
                if (out_hs) begin
                    state_d     = BUF_ONE;
                    head_data_d = tail_data_q;
                    head_strb_d = tail_strb_q;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        if (clear_i) begin
            state_d = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= BUF_EMPTY;
            head_data_q <= '0;
            tail_data_q <= '0;
            head_strb_q <= '0;
            tail_strb_q <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            tail_data_q <= tail_data_d;
            head_strb_q <= head_strb_d;
            tail_strb_q <= tail_strb_d;
        end
    end

endmodule

// File: rtl/hwpe_stream_serialize.sv
// Round-robin serializer: takes one beat from each input stream in turn and
// emits them on a single output stream through a 2-entry skid buffer.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : synchronous clear of stream counter and buffer
//   ctrl_i        : clear_serdes_state / first_stream, sampled on handshake
//   push_i[]      : input streams, only the selected one sees ready
//   pop_o         : serialized output stream
module hwpe_stream_serialize
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_IN_STREAMS = 2,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  ctrl_serdes_t           ctrl_i,
    hwpe_stream_intf_stream.sink   push_i [NB_IN_STREAMS-1:0],
    hwpe_stream_intf_stream.source pop_o
);

    localparam int unsigned CNT_W  = $clog2(NB_IN_STREAMS);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [CNT_W-1:0]                         stream_cnt_q, stream_cnt_d;
    logic [NB_IN_STREAMS-1:0]                 in_valid;
    logic [NB_IN_STREAMS-1:0][DATA_WIDTH-1:0] in_data;
    logic [NB_IN_STREAMS-1:0][STRB_W-1:0]     in_strb;
    logic                                     buf_ready;
    logic                                     in_hs;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DATA_WIDTH)) mux_s ();

    // Interface arrays can only be indexed by constants, so flatten them first.
    for (genvar ii = 0; ii < NB_IN_STREAMS; ii++) begin : g_in
        assign in_valid[ii]    = push_i[ii].valid;
        assign in_data[ii]     = push_i[ii].data;
        assign in_strb[ii]     = push_i[ii].strb;
        assign push_i[ii].ready = buf_ready & (stream_cnt_q == CNT_W'(ii));
    end

    assign mux_s.valid = in_valid[stream_cnt_q];
    assign mux_s.data  = in_data[stream_cnt_q];
    assign mux_s.strb  = in_strb[stream_cnt_q];
    assign buf_ready   = mux_s.ready;
    assign in_hs       = mux_s.valid & buf_ready;

    always_comb begin
        stream_cnt_d = stream_cnt_q + CNT_W'(1);
        if (ctrl_i.clear_serdes_state) begin
            // out-of-range start index falls back to stream 0
            if ({22'b0, ctrl_i.first_stream} < NB_IN_STREAMS) begin
                stream_cnt_d = ctrl_i.first_stream[CNT_W-1:0];
            end else begin
                stream_cnt_d = '0;
            end
        end else if (stream_cnt_q == CNT_W'(NB_IN_STREAMS - 1)) begin
            stream_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stream_cnt_q <= '0;
        end else if (clear_i) begin
            stream_cnt_q <= '0;
        end else if (in_hs) begin
            stream_cnt_q <= stream_cnt_d;
        end
    end

    hwpe_stream_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) i_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (mux_s),
        .pop_o   (pop_o)
    );

endmodule

// File: tb/tb_hwpe_stream_serialize.sv
module tb_hwpe_stream_serialize;
    import hwpe_stream_package::*;

    localparam int N  = 4;
    localparam int DW = 32;

    logic              clk_sys = 1'b0;
    logic              rst_n;
    logic              clear;
    ctrl_serdes_t      ctrl;
    logic [N-1:0]           in_valid;
    logic [N-1:0][DW-1:0]   in_data;
    logic [N-1:0][3:0]      in_strb;
    logic [N-1:0]           in_ready;
    logic              pop_ready;
    logic              pop_valid;
    logic [DW-1:0]     pop_data;
    logic [3:0]        pop_strb;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: next input to serve and the buffered beats {strb,data}
    int          m_sel;
    int          m_acc;
    logic [35:0] m_q[$];
    logic [31:0] obs[$];

    always #5 clk_sys = ~clk_sys;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push [N-1:0] ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop ();

    for (genvar g = 0; g < N; g++) begin : g_push
        assign push[g].valid = in_valid[g];
        assign push[g].data  = in_data[g];
        assign push[g].strb  = in_strb[g];
        assign in_ready[g]   = push[g].ready;
    end
    assign pop.ready = pop_ready;
    assign pop_valid = pop.valid;
    assign pop_data  = pop.data;
    assign pop_strb  = pop.strb;

    hwpe_stream_serialize #(
        .NB_IN_STREAMS (N),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk_i   (clk_sys),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .ctrl_i  (ctrl),
        .push_i  (push),
        .pop_o   (pop)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_sel = 0;
        m_acc = -1;
    endtask

    // Called just after a negedge with stimulus applied: compare, advance model, wait one cycle.
    task automatic step();
        bit full, do_in, do_out;
        check_val("pop_valid", pop_valid, 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_val("pop_data", pop_data, 64'(m_q[0][31:0]));
            check_val("pop_strb", pop_strb, 64'(m_q[0][35:32]));
        end
        for (int i = 0; i < N; i++)
            check_val($sformatf("ready%0d", i), in_ready[i], 64'(i == m_sel && m_q.size() < 2));
        if (pop_valid && pop_ready) obs.push_back(pop_data);

        full   = (m_q.size() == 2);
        do_in  = !full && in_valid[m_sel];
        do_out = (m_q.size() != 0) && pop_ready;
        m_acc  = -1;
        if (clear) begin
            m_q.delete();
            m_sel = 0;
        end else begin
            if (do_out) void'(m_q.pop_front());
            if (do_in) begin
                m_q.push_back({in_strb[m_sel], in_data[m_sel]});
                m_acc = m_sel;
                if (ctrl.clear_serdes_state)
                    m_sel = (int'(ctrl.first_stream) < N) ? int'(ctrl.first_stream) : 0;
                else
                    m_sel = (m_sel + 1) % N;
            end
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic set_rr_inputs();
        for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'b1;
            in_data[i]  = 32'h10 + 32'(i);
            in_strb[i]  = 4'hf;
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; ctrl = '0; pop_ready = 1'b1;
        in_valid = '0; in_data = '0; in_strb = '0;
        model_reset();
        @(negedge clk_sys); @(negedge clk_sys);
        check_val("rst_valid", pop_valid, 0);
        check_val("rst_data", pop_data, 0);
        check_val("rst_strb", pop_strb, 0);
        check_val("rst_ready", in_ready, 4'b0001);

        // round-robin at full rate from reset release
        set_rr_inputs();
        rst_n = 1'b1;
        obs.delete();
        for (int k = 0; k < 9; k++) step();
        check_val("rr_count", obs.size(), 8);
        for (int k = 0; k < 8 && k < obs.size(); k++)
            check_val($sformatf("rr_seq%0d", k), obs[k], 32'h10 + 32'(k % 4));

        // stall input 2
        for (int k = 0; k < 8 && m_sel != 0; k++) step();
        in_valid[2] = 1'b0;
        obs.delete();
        for (int k = 0; k < 6; k++) step();
        in_valid[2] = 1'b1;
        for (int k = 0; k < 6; k++) step();
        for (int k = 0; k + 1 < obs.size(); k++)
            check_val("stall_order", obs[k+1], 32'h10 + ((obs[k] - 32'h10 + 1) % 4));

        // backpressure
        pop_ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check_val("bp_ready", in_ready, 4'b0000);
        check_val("bp_valid", pop_valid, 1);
        pop_ready = 1'b1;
        obs.delete();
        for (int k = 0; k < 6; k++) step();
        for (int k = 0; k + 1 < obs.size(); k++)
            check_val("bp_order", obs[k+1], 32'h10 + ((obs[k] - 32'h10 + 1) % 4));

        // first_stream redirect
        for (int k = 0; k < 8 && m_sel != 0; k++) step();
        ctrl.clear_serdes_state = 1'b1; ctrl.first_stream = 10'd3;
        step();
        ctrl = '0;
        check_val("first3", in_ready, 4'b1000);
        ctrl.clear_serdes_state = 1'b1; ctrl.first_stream = 10'd7;
        step();
        ctrl = '0;
        check_val("first7", in_ready, 4'b0001);

        // clear while full with a valid input
        pop_ready = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check_val("pre_clr_ready", in_ready, 4'b0000);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_val("clr_valid", pop_valid, 0);
        check_val("clr_ready", in_ready, 4'b0001);
        pop_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || m_acc == i) begin
                    in_valid[i] = ($urandom_range(0, 3) != 0);
                    in_data[i]  = $urandom;
                    in_strb[i]  = 4'($urandom);
                end
            end
            pop_ready = ($urandom_range(0, 3) != 0);
            ctrl.clear_serdes_state = ($urandom_range(0, 7) == 0);
            ctrl.first_stream = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                            : 10'($urandom_range(0, 5));
            clear = ($urandom_range(0, 40) == 0);
            step();
        end
        clear = 1'b0; ctrl = '0;

        // asynchronous reset between edges
        set_rr_inputs();
        pop_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        @(posedge clk_sys);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_valid", pop_valid, 0);
        check_val("arst_data", pop_data, 0);
        check_val("arst_ready", in_ready, 4'b0001);
        @(negedge clk_sys);
        model_reset();
        rst_n = 1'b1;
        obs.delete();
        for (int k = 0; k < 6; k++) step();
        check_val("arst_first", (obs.size() > 0) ? obs[0] : 32'hdead, 32'h10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
